dmem_ws: RTL and testbench

Parametrised wait-state data memory for the xgriscv cores. It generalises the fixed single-cycle dmem with a configurable depth and access latency and a req/ready handshake. It also does byte/half/word lane handling and load sign/zero extension internally. It sits between the core's load/store path and the data array, and is intended for multi-cycle and pipelined core variants that can stall on memory.

---
 rtl/dmem_ws_pkg.sv | 18 +
 rtl/dmem_ws_align.sv | 62 ++++++
 rtl/dmem_ws.sv | 110 +++++++++++
 tb/tb_dmem_ws.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ws_pkg.sv
// Shared encodings for the xgriscv data-memory path: access sizes,
// wait-state FSM states and the wait-state bound.
package xgriscv_defines;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;

  localparam int unsigned WAIT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_ws_align.sv
// Combinational lane logic for dmem_ws: byte enables, store lane replication,
// load lane select and extension. Alignment trapping with DMEM_WS_ALIGN_TRAP_EN.
import xgriscv_defines::*;

module dmem_ws_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        lunsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rext,
  output logic        err
);

  logic [1:0]  sz;
  logic [1:0]  off;
  logic [31:0] sh;

  always_comb begin
    sz  = size;
    off = addr_lo;
    err = 1'b0;
`ifdef DMEM_WS_ALIGN_TRAP_EN
    err = (size == SZ_RSV) ||
          (size == SZ_HALF && addr_lo[0]) ||
          (size == SZ_WORD && addr_lo != 2'b00);
`else
    // Without trapping, misaligned accesses are forced down to natural alignment.
    if (sz == SZ_RSV) sz = SZ_WORD;
    if (sz == SZ_HALF) off[0] = 1'b0;
    if (sz == SZ_WORD) off = 2'b00;
`endif
  end

  assign sh = rword >> {off, 3'b000};

  always_comb begin
    be     = 4'b1111;
    wlanes = wdata;
    rext   = rword;
    case (sz)
      SZ_BYTE: begin
        be     = 4'b0001 << off;
        wlanes = {4{wdata[7:0]}};
        rext   = {{24{~lunsigned & sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        be     = 4'b0011 << off;
        wlanes = {2{wdata[15:0]}};
        rext   = {{16{~lunsigned & sh[15]}}, sh[15:0]};
      end
      default: begin
        be     = 4'b1111;
        wlanes = wdata;
        rext   = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ws.sv
// Wait-state data memory with req/ready handshake and internal lane handling.
// Optional alignment trap: define DMEM_WS_ALIGN_TRAP_EN.
import xgriscv_defines::*;

module dmem_ws #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            lunsigned,
  input  logic [31:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic [1:0]      dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Handshake: req is sampled only in IDLE/RESP and ignored in WAIT;
  // ready pulses for one cycle in RESP with rdata/err valid alongside it.
  dmem_state_e state, state_nx;
  logic [3:0]      cnt;
  logic            we_q, lu_q;
  logic [1:0]      size_q;
  logic [AW+1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   widx;
  logic [XLEN-1:0] rword, wlanes, rext;
  logic [3:0]      be;
  logic            aerr, accept, access;
  logic            unused_addr;

  assign unused_addr = ^addr[31:AW+2];
  assign widx        = addr_q[AW+1:2];
  assign rword       = mem[widx];
  assign accept      = req && (state != ST_WAIT);
  assign access      = (state == ST_WAIT) && (cnt == 4'd0);
  assign dbg_state   = state;

  dmem_ws_align u_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .lunsigned (lu_q),
    .wdata     (wdata_q),
    .rword     (rword),
    .be        (be),
    .wlanes    (wlanes),
    .rext      (rext),
    .err       (aerr)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_RESP: state_nx = req ? ST_WAIT : ST_IDLE;
      ST_WAIT:          if (cnt == 4'd0) state_nx = ST_RESP;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      ready <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ST_WAIT);
      ready <= (state_nx == ST_RESP);
      if (accept) begin
        cnt     <= WAIT_INIT;
        we_q    <= we;
        size_q  <= size;
        lu_q    <= lunsigned;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err   <= aerr;
        rdata <= (aerr || we_q) ? '0 : rext;
      end
    end
  end

  // Array is never reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q && !aerr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ws.sv
// Self-checking bench for dmem_ws: byte-level reference model, directed
// scenarios and randomized traffic on WAIT_CYCLES=2, plus a WAIT_CYCLES=0 instance.
module tb_dmem_ws;

  localparam int TB_DEPTH = 1024;
  localparam int WC       = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, req0 = 1'b0;
  logic        we = 1'b0, lunsigned = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, ready, err, busy0, ready0, err0;
  logic [31:0] rdata, rdata0;
  logic [1:0]  dbg_state, dbg_state0;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mb [TB_DEPTH*4];

  always #5 clk = ~clk;

  dmem_ws #(.XLEN(32), .DEPTH(TB_DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .lunsigned(lunsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .ready(ready), .rdata(rdata), .err(err), .dbg_state(dbg_state)
  );

  dmem_ws #(.XLEN(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .size(size),
    .lunsigned(lunsigned), .addr(addr), .wdata(wdata),
    .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0), .dbg_state(dbg_state0)
  );

  // Reference: byte-addressed memory, natural-alignment rules, plain extension.
  function automatic void mref(input logic w, input logic [1:0] s, input logic u,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output logic er);
    int n, base;
    logic [31:0] v;
    n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    base = int'(a % (TB_DEPTH * 4));
    rd   = '0;
    er   = 1'b0;
`ifdef DMEM_WS_ALIGN_TRAP_EN
    if (s == 2'd3 || (base % n) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    base = base - (base % n);
    if (w) begin
      for (int i = 0; i < n; i++) mb[base+i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base+i];
      if (n < 4 && !u && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      rd = v;
    end
  endfunction

  // Caller sits at a negedge; returns at the negedge where ready was seen.
  task automatic do_txn(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nb);
    req = 1'b1; we = w; size = s; lunsigned = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); lunsigned = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    lat = -1; nb = 0; rd = 'x; er = 1'bx;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (busy) nb++;
      if (ready) begin
        lat = n; rd = rdata; er = err;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", ready); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_chk++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd, erd; logic er, eer; int lat, nb;
    mref(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, erd, eer);
    do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, nb);
    n_chk++; if (lat != WC + 2) begin n_fail++; $display("FAIL word_st_lat got %0d exp %0d", lat, WC + 2); end
    n_chk++; if (nb != WC + 1) begin n_fail++; $display("FAIL word_st_busy got %0d exp %0d", nb, WC + 1); end
    n_chk++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL word_st_resp got %h/%b exp 0/0", rd, er); end
    @(negedge clk);
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nb);
    n_chk++; if (lat != WC + 2) begin n_fail++; $display("FAIL word_ld_lat got %0d exp %0d", lat, WC + 2); end
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_ld_rdata got %h exp deadbeef", rd); end
    n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL word_ld_err got %b exp 0", er); end
  endtask

  task automatic test_byte();
    logic [31:0] rd, erd; logic er, eer; int lat, nb;
    mref(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, erd, eer);
    do_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, rd, er, lat, nb);
    do_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_signed got %h exp ffffff80", rd); end
    do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL byte_unsigned got %h exp 00000080", rd); end
    mref(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eer);
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== erd || rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL byte_word got %h exp 80adbeef", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd; logic er, eer; int lat, nb;
    mref(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, erd, eer);
    do_txn(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== erd || er !== eer) begin n_fail++; $display("FAIL misal_half got %h/%b exp %h/%b", rd, er, erd, eer); end
    n_chk++; if (lat != WC + 2) begin n_fail++; $display("FAIL misal_lat got %0d exp %0d", lat, WC + 2); end
    mref(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, erd, eer);
    do_txn(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, rd, er, lat, nb);
    n_chk++; if (rd !== 32'h0 || er !== eer) begin n_fail++; $display("FAIL misal_store got %h/%b exp 0/%b", rd, er, eer); end
    mref(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eer);
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL misal_mem got %h exp %h", rd, erd); end
    mref(1'b0, 2'd3, 1'b1, 32'h10, 32'h0, erd, eer);
    do_txn(1'b0, 2'd3, 1'b1, 32'h10, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== erd || er !== eer) begin n_fail++; $display("FAIL rsv_size got %h/%b exp %h/%b", rd, er, erd, eer); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; logic er, eer; int lat, nb;
    mref(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000A55A, erd, eer);
    do_txn(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000A55A, rd, er, lat, nb);
    mref(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, erd, eer);
    do_txn(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, rd, er, lat, nb);
    n_chk++; if (lat != WC + 2) begin n_fail++; $display("FAIL b2b_lat got %0d exp %0d", lat, WC + 2); end
    n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL b2b_rdata got %h exp %h", rd, erd); end
  endtask

  task automatic test_req_in_wait();
    logic [31:0] rd, erd; logic er, eer; int lat, nb, nrdy, first;
    mref(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eer);
    req = 1'b1; we = 1'b0; size = 2'd2; lunsigned = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    req = 1'b0;
    nrdy = 0; first = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ready) begin
        nrdy++;
        if (first < 0) begin first = n; rd = rdata; end
      end
      if (n == 1) begin
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'h0;
      end else begin
        req = 1'b0;
      end
    end
    n_chk++; if (nrdy != 1 || first != WC + 2) begin n_fail++; $display("FAIL wait_req_ready got %0d@%0d exp 1@%0d", nrdy, first, WC + 2); end
    n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL wait_req_rdata got %h exp %h", rd, erd); end
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL wait_req_mem got %h exp %h", rd, erd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int lat, nb, nrdy;
    mref(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, erd, eer);
    do_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, lat, nb);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h11111111;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || dbg_state !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_outs got b%b r%b e%b d%h s%b exp all 0", busy, ready, err, rdata, dbg_state);
    end
    reset = 1'b0;
    nrdy = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    n_chk++; if (nrdy != 0) begin n_fail++; $display("FAIL rstmid_ready got %0d exp 0", nrdy); end
    mref(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, erd, eer);
    do_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== erd || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rstmid_mem got %h exp cafef00d", rd); end
  endtask

  task automatic test_alias();
    logic [31:0] rd, erd, v; logic er, eer; int lat, nb;
    v = $urandom;
    mref(1'b1, 2'd2, 1'b0, TB_DEPTH * 4 + 32'h20, v, erd, eer);
    do_txn(1'b1, 2'd2, 1'b0, TB_DEPTH * 4 + 32'h20, v, rd, er, lat, nb);
    do_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== v) begin n_fail++; $display("FAIL alias_word got %h exp %h", rd, v); end
    mref(1'b0, 2'd0, 1'b1, TB_DEPTH * 8 + 32'h21, 32'h0, erd, eer);
    do_txn(1'b0, 2'd0, 1'b1, TB_DEPTH * 8 + 32'h21, 32'h0, rd, er, lat, nb);
    n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL alias_byte got %h exp %h", rd, erd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eer, w, u; logic [1:0] s; int lat, nb;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      mref(1'b1, 2'd2, 1'b0, 32'(i * 4), d, erd, eer);
      do_txn(1'b1, 2'd2, 1'b0, 32'(i * 4), d, rd, er, lat, nb);
    end
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
      d = $urandom;
      mref(w, s, u, a, d, erd, eer);
      do_txn(w, s, u, a, d, rd, er, lat, nb);
      n_chk++; if (rd !== erd || er !== eer || lat != WC + 2) begin
        n_fail++; $display("FAIL rand_%0d got %h/%b/%0d exp %h/%b/%0d", i, rd, er, lat, erd, eer, WC + 2);
      end
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  task automatic test_wait0();
    logic [31:0] rd; int lat, nb;
    for (int k = 0; k < 2; k++) begin
      req0 = 1'b1; we = (k == 0); size = 2'd2; lunsigned = 1'b0; addr = 32'h4; wdata = 32'h5A5A1234;
      @(posedge clk); #1;
      req0 = 1'b0; wdata = $urandom;
      lat = -1; nb = 0; rd = 'x;
      for (int n = 1; n <= 10 && lat < 0; n++) begin
        @(negedge clk);
        if (busy0) nb++;
        if (ready0) begin lat = n; rd = rdata0; end
      end
      n_chk++; if (lat != 2) begin n_fail++; $display("FAIL w0_lat_%0d got %0d exp 2", k, lat); end
      n_chk++; if (nb != 1) begin n_fail++; $display("FAIL w0_busy_%0d got %0d exp 1", k, nb); end
    end
    n_chk++; if (rd !== 32'h5A5A1234 || err0 !== 1'b0) begin n_fail++; $display("FAIL w0_rdata got %h/%b exp 5a5a1234/0", rd, err0); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_misalign();
    test_back_to_back();
    test_req_in_wait();
    test_reset_mid();
    test_alias();
    @(negedge clk);
    test_wait0();
    @(negedge clk);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
